// File: rtl/bus_switch_rr.sv
// Shared-path bus switch with round-robin arbitration over NPORT ports.
// It runs one transaction at a time: arbitrate and decode in IDLE, forward
// the request to the slave, wait for the slave to answer, then stream the
// response back to the master. A timeout or an illegal target ends the
// transaction with an error reply.
module bus_switch_rr #(
  parameter int              NPORT     = 6,
  parameter int              DW        = 32,
  parameter int              NDEV      = 4,
  parameter logic [DW-1:0]   DEV_BASE  = 32'hF000_0000,
  parameter int              DEV_SHIFT = 8,
  parameter int              MEM_PORT  = 5,
  parameter int              BURST_LEN = 16,
  parameter int              TIMEOUT   = 255,
  parameter logic [2:0]      ERR_CMD   = 3'b111,
  localparam int             PW        = $clog2(NPORT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    reqout,
  input  logic [NPORT*DW-1:0] addrdataout,
  input  logic [NPORT*3-1:0]  cmdout,
  input  logic [NPORT*2-1:0]  lenout,
  output logic [NPORT-1:0]    ackin,
  output logic [NPORT*DW-1:0] addrdatain,
  output logic [NPORT*3-1:0]  cmdin,
  output logic [NPORT-1:0]    selin,
  output logic [NPORT*2-1:0]  lenin,
  output logic                busy,
  output logic [PW-1:0]       grant,
  output logic                err
);

  // A zero TIMEOUT disables the timer, but the counter still needs a bit.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int LO = DEV_SHIFT + PW;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;        // 0 = first REQ cycle, 1 = second
  logic [PW-1:0]   mst_q, mst_d;
  logic [PW-1:0]   slv_q, slv_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic            from_idle_q, from_idle_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   beats_q, beats_d;

  logic            any_req;
  logic [PW-1:0]   win;
  logic [DW-1:0]   win_addr;
  logic [PW-1:0]   dev_idx;
  logic [PW-1:0]   dec_slv;

  // Round-robin scan: first requester above the pointer, wrapping at NPORT.
  always_comb begin
    int cand;
    cand    = 0;
    any_req = 1'b0;
    win     = '0;
    for (int i = 1; i <= NPORT; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NPORT) cand = cand - NPORT;
      if (!any_req && reqout[PW'(cand)]) begin
        any_req = 1'b1;
        win     = PW'(cand);
      end
    end
  end

  // Address decode of the winner: device window hit or fall back to memory.
  always_comb begin
    win_addr = addrdataout[int'(win)*DW +: DW];
    dev_idx  = win_addr[DEV_SHIFT +: PW];
    if (win_addr[DW-1:LO] == DEV_BASE[DW-1:LO] && int'(dev_idx) < NDEV) begin
      dec_slv = dev_idx;
    end else begin
      dec_slv = PW'(MEM_PORT);
    end
  end

  // Next-state logic for the transaction sequencer and its bookkeeping.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    mst_d       = mst_q;
    slv_d       = slv_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    from_idle_d = from_idle_q;
    timer_d     = timer_q;
    beats_d     = beats_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          mst_d   = win;
          slv_d   = dec_slv;
          rr_d    = win;
          addr_d  = win_addr;
          beats_d = (lenout[int'(win)*2 +: 2] == 2'b11) ? BW'(BURST_LEN) : BW'(1);
          timer_d = '0;
          phase_d = 1'b0;
          if (dec_slv == win) begin
            state_d     = S_ERR;
            from_idle_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            from_idle_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        phase_d = 1'b1;
        if (phase_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (reqout[slv_q]) begin
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        beats_d = beats_q - 1'b1;
        if (beats_q == BW'(1)) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output steering: forward master to slave in REQ, slave to master in RESP.
  always_comb begin
    ackin      = '0;
    selin      = '0;
    addrdatain = '0;
    cmdin      = '0;
    lenin      = '0;
    err        = 1'b0;
    unique case (state_q)
      S_REQ: begin
        selin[slv_q]                          = 1'b1;
        addrdatain[int'(slv_q)*DW +: DW]      = addrdataout[int'(mst_q)*DW +: DW];
        cmdin[int'(slv_q)*3 +: 3]             = cmdout[int'(mst_q)*3 +: 3];
        lenin[int'(slv_q)*2 +: 2]             = lenout[int'(mst_q)*2 +: 2];
        ackin[mst_q]                          = ~phase_q;
      end
      S_WAIT: begin
        ackin[slv_q] = reqout[slv_q];
      end
      S_RESP: begin
        selin[mst_q]                          = 1'b1;
        addrdatain[int'(mst_q)*DW +: DW]      = addrdataout[int'(slv_q)*DW +: DW];
        cmdin[int'(mst_q)*3 +: 3]             = cmdout[int'(slv_q)*3 +: 3];
        lenin[int'(mst_q)*2 +: 2]             = lenout[int'(slv_q)*2 +: 2];
      end
      S_ERR: begin
        selin[mst_q]                          = 1'b1;
        addrdatain[int'(mst_q)*DW +: DW]      = addr_q;
        cmdin[int'(mst_q)*3 +: 3]             = ERR_CMD;
        ackin[mst_q]                          = from_idle_q;
        err                                   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign grant = mst_q;

  // State and bookkeeping registers; reset puts port 0 first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      mst_q       <= '0;
      slv_q       <= '0;
      rr_q        <= PW'(NPORT - 1);
      addr_q      <= '0;
      from_idle_q <= 1'b0;
      timer_q     <= '0;
      beats_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      phase_q     <= phase_d;
      mst_q       <= mst_d;
      slv_q       <= slv_d;
      rr_q        <= rr_d;
      addr_q      <= addr_d;
      from_idle_q <= from_idle_d;
      timer_q     <= timer_d;
      beats_q     <= beats_d;
    end
  end

endmodule

// File: tb/tb_bus_switch_rr.sv
// Bench for bus_switch_rr: transaction-level reference model compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_bus_switch_rr;

  localparam int NPORT   = 6;
  localparam int DW      = 32;
  localparam int PW      = 3;
  localparam int NDEV    = 4;
  localparam int MEMP    = 5;
  localparam int TMO     = 255;
  localparam logic [31:0] BASE = 32'hF000_0000;

  localparam int K_ACK = 0;
  localparam int K_SEL = 1;
  localparam int K_ERR = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NPORT-1:0]    reqout;
  logic [NPORT*DW-1:0] addrdataout;
  logic [NPORT*3-1:0]  cmdout;
  logic [NPORT*2-1:0]  lenout;
  logic [NPORT-1:0]    ackin;
  logic [NPORT*DW-1:0] addrdatain;
  logic [NPORT*3-1:0]  cmdin;
  logic [NPORT-1:0]    selin;
  logic [NPORT*2-1:0]  lenin;
  logic                busy;
  logic [PW-1:0]       grant;
  logic                err;

  bus_switch_rr dut (
    .clk(clk), .reset(reset), .reqout(reqout), .addrdataout(addrdataout),
    .cmdout(cmdout), .lenout(lenout), .ackin(ackin), .addrdatain(addrdatain),
    .cmdin(cmdin), .selin(selin), .lenin(lenin), .busy(busy),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: a transaction record plus a cycle index inside it.
  bit          m_busy = 0, m_bad = 0, m_resp = 0, m_to = 0;
  int          m_mst = 0, m_slv = 0, m_left = 0, m_t = 0, m_wait = 0;
  int          m_ptr = NPORT - 1, m_grant = 0;
  logic [31:0] m_addr = '0;

  // Observation counters used by the directed scenarios.
  int          cyc = 0;
  int          cnt_sel [NPORT];
  int          cnt_ack [NPORT];
  int          ack_cyc [NPORT];
  logic [31:0] sel_ad  [NPORT];
  int          cnt_err = 0, err_cyc = 0;
  logic [NPORT*3-1:0] err_cmdin = '0;

  initial begin
    for (int p = 0; p < NPORT; p++) begin
      cnt_sel[p] = 0; cnt_ack[p] = 0; ack_cyc[p] = 0; sel_ad[p] = '0;
    end
  end

  // Model step and compare, once per cycle on the falling edge.
  always @(negedge clk) begin : model_cmp
    logic [NPORT-1:0]    e_ack, e_sel;
    logic [NPORT*DW-1:0] e_ad;
    logic [NPORT*3-1:0]  e_cmd;
    logic [NPORT*2-1:0]  e_len;
    logic                e_busy, e_err;
    int                  e_grant, w, s;
    bit                  found;
    logic [31:0]         a;
    e_ack = '0; e_sel = '0; e_ad = '0; e_cmd = '0; e_len = '0;
    e_busy = 0; e_err = 0; e_grant = 0; w = 0; s = 0; found = 0; a = '0;
    if (!reset) begin
      m_busy = 0; m_ptr = NPORT - 1; m_grant = 0;
    end else if (!m_busy) begin
      e_grant = m_grant;
      for (int i = 1; i <= NPORT; i++) begin
        if (!found && reqout[(m_ptr + i) % NPORT]) begin
          found = 1; w = (m_ptr + i) % NPORT;
        end
      end
      if (found) begin
        a = addrdataout[w*DW +: DW];
        if (a >= BASE && (a - BASE) < NDEV * 256) s = int'((a - BASE) >> 8);
        else s = MEMP;
        m_busy = 1; m_mst = w; m_slv = s; m_addr = a; m_bad = (s == w);
        m_left = (lenout[w*2 +: 2] == 2'b11) ? 16 : 1;
        m_t = 1; m_wait = 0; m_resp = 0; m_to = 0;
        m_ptr = w; m_grant = w;
      end
    end else begin
      e_busy = 1; e_grant = m_grant;
      if (m_bad || m_to) begin
        e_sel[m_mst] = 1; e_err = 1; e_ack[m_mst] = m_bad;
        e_cmd[m_mst*3 +: 3] = 3'b111; e_ad[m_mst*DW +: DW] = m_addr;
        m_busy = 0;
      end else if (m_t <= 2) begin
        e_sel[m_slv] = 1; e_ack[m_mst] = (m_t == 1);
        e_ad[m_slv*DW +: DW] = addrdataout[m_mst*DW +: DW];
        e_cmd[m_slv*3 +: 3]  = cmdout[m_mst*3 +: 3];
        e_len[m_slv*2 +: 2]  = lenout[m_mst*2 +: 2];
      end else if (m_resp) begin
        e_sel[m_mst] = 1;
        e_ad[m_mst*DW +: DW] = addrdataout[m_slv*DW +: DW];
        e_cmd[m_mst*3 +: 3]  = cmdout[m_slv*3 +: 3];
        e_len[m_mst*2 +: 2]  = lenout[m_slv*2 +: 2];
        m_left--;
        if (m_left == 0) m_busy = 0;
      end else begin
        m_wait++;
        if (reqout[m_slv]) begin
          e_ack[m_slv] = 1; m_resp = 1;
        end else if (TMO != 0 && m_wait == TMO) begin
          m_to = 1;
        end
      end
      m_t++;
    end
    check("ackin",      256'(ackin),      256'(e_ack));
    check("selin",      256'(selin),      256'(e_sel));
    check("addrdatain", 256'(addrdatain), 256'(e_ad));
    check("cmdin",      256'(cmdin),      256'(e_cmd));
    check("lenin",      256'(lenin),      256'(e_len));
    check("busy",       256'(busy),       256'(e_busy));
    check("grant",      256'(grant),      256'(e_grant));
    check("err",        256'(err),        256'(e_err));
    cyc++;
    for (int p = 0; p < NPORT; p++) begin
      if (selin[p]) begin cnt_sel[p]++; sel_ad[p] = addrdatain[p*DW +: DW]; end
      if (ackin[p]) begin cnt_ack[p]++; ack_cyc[p] = cyc; end
    end
    if (err) begin cnt_err++; err_cyc = cyc; err_cmdin = cmdin; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [2:0] c, input logic [1:0] l);
    addrdataout[p*DW +: DW] = a;
    cmdout[p*3 +: 3]        = c;
    lenout[p*2 +: 2]        = l;
  endtask

  // Wait (bounded) for ackin[p], selin[p] or err; returns just after the
  // rising edge that follows the cycle in which it was seen.
  task automatic wait_bit(input int kind, input int p, input int budget, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (kind == K_ACK && ackin[p]) ok = 1;
      if (kind == K_SEL && selin[p]) ok = 1;
      if (kind == K_ERR && err)      ok = 1;
    end
    check(nm, 256'(ok), 256'(1));
    tick();
  endtask

  // Slave answers: raise the request, then present one beat per cycle.
  task automatic respond(input int p, input logic [31:0] d, input logic [2:0] c, input int nbeats, input string nm);
    set_port(p, d, c, 2'b00);
    reqout[p] = 1'b1;
    wait_bit(K_ACK, p, 300, nm);
    reqout[p] = 1'b0;
    for (int b = 1; b < nbeats; b++) begin
      tick();
      set_port(p, d + 32'(b), c, 2'b00);
    end
    tick();
    set_port(p, '0, 3'b000, 2'b00);
  endtask

  int s_sel [NPORT];
  int s_ack [NPORT];
  int s_err;
  int g [4];
  int others;

  initial begin
    reset = 1'b0; reqout = '0; addrdataout = '0; cmdout = '0; lenout = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  256'(busy),  256'(0));
    check("rst_grant", 256'(grant), 256'(0));
    check("rst_selin", 256'(selin), 256'(0));
    reset = 1'b1;
    tick();

    // 1: port 4 -> dev2, slave answers three cycles into the wait.
    s_sel = cnt_sel; s_ack = cnt_ack;
    set_port(4, 32'hF000_0200, 3'b001, 2'b00);
    reqout[4] = 1'b1;
    wait_bit(K_ACK, 4, 20, "t1_ack4_seen");
    reqout[4] = 1'b0;
    tick(); tick(); tick();
    respond(2, 32'hCAFE_0002, 3'b010, 1, "t1_ack2_seen");
    check("t1_sel2_cycles", 256'(cnt_sel[2] - s_sel[2]), 256'(2));
    check("t1_sel2_addr",   256'(sel_ad[2]),             256'(32'hF000_0200));
    check("t1_ack4_cycles", 256'(cnt_ack[4] - s_ack[4]), 256'(1));
    check("t1_ack2_cycles", 256'(cnt_ack[2] - s_ack[2]), 256'(1));
    check("t1_beats4",      256'(cnt_sel[4] - s_sel[4]), 256'(1));
    check("t1_beat4_data",  256'(sel_ad[4]),             256'(32'hCAFE_0002));
    check("t1_busy_after",  256'(busy),                  256'(0));

    // 2: ports 0, 2, 4 contend continuously -> grants 0, 2, 4, 0.
    set_port(0, 32'h0000_1000, 3'b001, 2'b00);
    set_port(2, 32'h0000_2000, 3'b001, 2'b00);
    set_port(4, 32'h0000_3000, 3'b001, 2'b00);
    reqout[0] = 1'b1; reqout[2] = 1'b1; reqout[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_bit(K_SEL, MEMP, 50, "t2_sel5_seen");
      g[k] = int'(grant);
      if (k == 3) reqout = '0;
      respond(MEMP, 32'hB000_0000 + 32'(k), 3'b010, 1, "t2_ack5_seen");
    end
    check("t2_grant0", 256'(g[0]), 256'(0));
    check("t2_grant1", 256'(g[1]), 256'(2));
    check("t2_grant2", 256'(g[2]), 256'(4));
    check("t2_grant3", 256'(g[3]), 256'(0));

    // 3: port 1 burst read from memory, 16 beats, no underflow afterwards.
    s_sel = cnt_sel;
    set_port(1, 32'h0000_1000, 3'b011, 2'b11);
    reqout[1] = 1'b1;
    wait_bit(K_ACK, 1, 20, "t3_ack1_seen");
    reqout[1] = 1'b0;
    respond(MEMP, 32'hD000_0000, 3'b100, 16, "t3_ack5_seen");
    repeat (5) tick();
    check("t3_sel5_cycles", 256'(cnt_sel[5] - s_sel[5]), 256'(2));
    check("t3_beats1",      256'(cnt_sel[1] - s_sel[1]), 256'(16));
    check("t3_last_beat",   256'(sel_ad[1]),             256'(32'hD000_000F));
    check("t3_busy_after",  256'(busy),                  256'(0));

    // 4: port 0 -> dev3, which never answers: timeout error reply.
    s_sel = cnt_sel; s_err = cnt_err;
    set_port(0, 32'hF000_0300, 3'b001, 2'b00);
    reqout[0] = 1'b1;
    wait_bit(K_ACK, 0, 20, "t4_ack0_seen");
    reqout[0] = 1'b0;
    wait_bit(K_ERR, 0, 300, "t4_err_seen");
    check("t4_busy_after", 256'(busy), 256'(0));
    repeat (3) tick();
    check("t4_err_pulses",  256'(cnt_err - s_err),       256'(1));
    check("t4_err_latency", 256'(err_cyc - ack_cyc[0]),  256'(257));
    check("t4_err_cmd0",    256'(err_cmdin[2:0]),        256'(3'b111));
    check("t4_sel3_cycles", 256'(cnt_sel[3] - s_sel[3]), 256'(2));

    // 5: port 2 targets itself: error straight from IDLE with ack.
    s_sel = cnt_sel; s_ack = cnt_ack; s_err = cnt_err;
    set_port(2, 32'hF000_0200, 3'b001, 2'b00);
    reqout[2] = 1'b1;
    wait_bit(K_ERR, 0, 20, "t5_err_seen");
    reqout[2] = 1'b0;
    repeat (3) tick();
    others = 0;
    for (int p = 0; p < NPORT; p++) if (p != 2) others += cnt_sel[p] - s_sel[p];
    check("t5_err_pulses", 256'(cnt_err - s_err),       256'(1));
    check("t5_ack2",       256'(cnt_ack[2] - s_ack[2]), 256'(1));
    check("t5_sel2",       256'(cnt_sel[2] - s_sel[2]), 256'(1));
    check("t5_sel_others", 256'(others),                256'(0));
    check("t5_err_addr",   256'(sel_ad[2]),             256'(32'hF000_0200));

    // 6: reset during beat 5 of a 16-beat response.
    set_port(0, 32'h0000_4000, 3'b001, 2'b11);
    reqout[0] = 1'b1;
    wait_bit(K_ACK, 0, 20, "t6_ack0_seen");
    reqout[0] = 1'b0;
    set_port(MEMP, 32'hE000_0000, 3'b010, 2'b00);
    reqout[MEMP] = 1'b1;
    wait_bit(K_ACK, MEMP, 20, "t6_ack5_seen");
    reqout[MEMP] = 1'b0;
    for (int b = 1; b < 5; b++) begin
      tick();
      set_port(MEMP, 32'hE000_0000 + 32'(b), 3'b010, 2'b00);
    end
    #1 reset = 1'b0;
    #1;
    check("t6_async_busy",  256'(busy),       256'(0));
    check("t6_async_sel",   256'(selin),      256'(0));
    check("t6_async_ad",    256'(addrdatain), 256'(0));
    check("t6_async_grant", 256'(grant),      256'(0));
    set_port(MEMP, '0, 3'b000, 2'b00);
    tick(); tick();
    reset = 1'b1;
    s_sel = cnt_sel;
    set_port(0, 32'h0000_5000, 3'b001, 2'b00);
    set_port(2, 32'h0000_6000, 3'b001, 2'b00);
    reqout[0] = 1'b1; reqout[2] = 1'b1;
    wait_bit(K_SEL, MEMP, 20, "t6_sel5_seen");
    check("t6_first_grant", 256'(grant), 256'(0));
    reqout = '0;
    respond(MEMP, 32'hA000_0000, 3'b010, 1, "t6_ack5_seen");
    repeat (3) tick();
    check("t6_beats0", 256'(cnt_sel[0] - s_sel[0]), 256'(1));
    check("t6_idle",   256'(busy),                  256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
